// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: X = A - B, one DIGIT_WIDTH-bit digit per clock, LSB first.
// Operands arrive and the (DATA_WIDTH+1)-bit result leaves over valid/ready handshakes.
module serial_subtractor #(
   parameter int DATA_WIDTH  = 4,
   parameter int DIGIT_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] sub_A,
   input  logic [DATA_WIDTH-1:0] sub_B,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH:0]   sub_X,
   output logic                  busy
);

   localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
   localparam int COUNT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [COUNT_W-1:0] LAST_DIGIT = COUNT_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [DATA_WIDTH-1:0]  r_opA;
   logic [DATA_WIDTH-1:0]  r_opB;
   logic [DATA_WIDTH-1:0]  r_diff;
   logic                   r_sign;
   logic                   r_borrow;
   logic [COUNT_W-1:0]     r_count;

   logic [DIGIT_WIDTH:0]   w_digitResult;
   logic                   w_accept;
   logic                   w_release;
   logic                   w_lastDigit;

   assign in_ready  = (r_state == IDLE) && !rst;
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == RUN) || (r_state == DONE);
   assign sub_X     = {r_sign, r_diff};

   assign w_accept    = in_valid && in_ready;
   assign w_release   = out_valid && out_ready;
   assign w_lastDigit = (r_count == LAST_DIGIT);

   // The low digit of each shifted operand is always the digit being processed;
   // the top bit of the widened difference is the borrow out of that digit.
   assign w_digitResult = {1'b0, r_opA[DIGIT_WIDTH-1:0]}
                        - {1'b0, r_opB[DIGIT_WIDTH-1:0]}
                        - {{DIGIT_WIDTH{1'b0}}, r_borrow};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: accept in IDLE, step through every digit in RUN, hold in DONE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (w_lastDigit) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (w_release) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Operand shifters carry no reset: their contents only matter after an accept.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_opA <= sub_A;
         r_opB <= sub_B;
      end else if (r_state == RUN) begin
         r_opA <= r_opA >> DIGIT_WIDTH;
         r_opB <= r_opB >> DIGIT_WIDTH;
      end
   end

   // Each RUN cycle shifts the new difference digit in from the top, so after
   // the last digit r_diff holds the full difference in its natural position.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_diff   <= '0;
         r_sign   <= 1'b0;
         r_borrow <= 1'b0;
         r_count  <= '0;
      end else if (w_accept) begin
         r_borrow <= 1'b0;
         r_count  <= '0;
      end else if (r_state == RUN) begin
         r_diff   <= DATA_WIDTH'({w_digitResult[DIGIT_WIDTH-1:0], r_diff} >> DIGIT_WIDTH);
         r_borrow <= w_digitResult[DIGIT_WIDTH];
         r_count  <= r_count + COUNT_W'(1);
         if (w_lastDigit) begin
            r_sign <= w_digitResult[DIGIT_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and streamed checks of serial_subtractor in a 4-bit/1-bit-digit and
// an 8-bit/4-bit-digit configuration; expected results are computed by hand.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;

   logic       inValidN, inReadyN, outValidN, outReadyN, busyN;
   logic [3:0] subAN, subBN;
   logic [4:0] subXN;

   logic       inValidW, inReadyW, outValidW, outReadyW, busyW;
   logic [7:0] subAW, subBW;
   logic [8:0] subXW;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.DATA_WIDTH(4), .DIGIT_WIDTH(1)) dutNarrow (
      .clk(clk), .rst(rst),
      .in_valid(inValidN), .in_ready(inReadyN),
      .sub_A(subAN), .sub_B(subBN),
      .out_valid(outValidN), .out_ready(outReadyN),
      .sub_X(subXN), .busy(busyN)
   );

   serial_subtractor #(.DATA_WIDTH(8), .DIGIT_WIDTH(4)) dutWide (
      .clk(clk), .rst(rst),
      .in_valid(inValidW), .in_ready(inReadyW),
      .sub_A(subAW), .sub_B(subBW),
      .out_valid(outValidW), .out_ready(outReadyW),
      .sub_X(subXW), .busy(busyW)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One operation on the narrow instance; holdCycles keeps out_ready low in DONE
   // while unrelated in_valid pulses are offered.
   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                input logic [4:0] expX, input int holdCycles);
      int waitCycles = 0;
      while (!inReadyN && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("inReadyIdle", 32'(inReadyN), 1);
      subAN = a; subBN = b; inValidN = 1'b1; outReadyN = 1'b0;
      @(negedge clk);
      inValidN = 1'b0; subAN = 4'hF; subBN = 4'h0;
      checkOutput("busyRun", 32'(busyN), 1);
      waitCycles = 0;
      while (!outValidN && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("latency", waitCycles, 4);
      checkOutput("resultX", 32'(subXN), 32'(expX));
      checkOutput("inReadyDone", 32'(inReadyN), 0);
      for (int h = 0; h < holdCycles; h++) begin
         inValidN = 1'b1; subAN = 4'hF; subBN = 4'h0;
         @(negedge clk);
         checkOutput("holdValid", 32'(outValidN), 1);
         checkOutput("holdX", 32'(subXN), 32'(expX));
         checkOutput("holdInReady", 32'(inReadyN), 0);
      end
      inValidN = 1'b0;
      outReadyN = 1'b1;
      @(negedge clk);
      outReadyN = 1'b0;
      checkOutput("releaseValid", 32'(outValidN), 0);
      checkOutput("releaseBusy", 32'(busyN), 0);
      checkOutput("releaseInReady", 32'(inReadyN), 1);
      checkOutput("releaseKeepX", 32'(subXN), 32'(expX));
   endtask

   task automatic applyStimulusWide(input logic [7:0] a, input logic [7:0] b, input logic [8:0] expX);
      int waitCycles = 0;
      checkOutput("wideInReady", 32'(inReadyW), 1);
      subAW = a; subBW = b; inValidW = 1'b1; outReadyW = 1'b1;
      @(negedge clk);
      inValidW = 1'b0; subAW = 8'hFF; subBW = 8'h00;
      while (!outValidW && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("wideLatency", waitCycles, 2);
      checkOutput("wideX", 32'(subXW), 32'(expX));
      @(negedge clk);
      checkOutput("wideRelease", 32'(outValidW), 0);
   endtask

   initial begin
      logic [4:0] expQ[$];
      logic       fireIn;
      int         sent, received, cycles;

      rst = 1'b1;
      inValidN = 1'b0; outReadyN = 1'b0; subAN = '0; subBN = '0;
      inValidW = 1'b0; outReadyW = 1'b0; subAW = '0; subBW = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstInReady", 32'(inReadyN), 0);
      checkOutput("rstOutValid", 32'(outValidN), 0);
      checkOutput("rstBusy", 32'(busyN), 0);
      checkOutput("rstX", 32'(subXN), 0);
      rst = 1'b0;
      #1;
      checkOutput("idleInReady", 32'(inReadyN), 1);
      @(negedge clk);

      applyStimulus(4'd5, 4'd3, 5'b00010, 0);
      applyStimulus(4'd3, 4'd5, 5'b11110, 0);
      applyStimulus(4'd0, 4'd15, 5'b10001, 0);
      applyStimulus(4'd15, 4'd15, 5'b00000, 0);
      applyStimulus(4'd9, 4'd4, 5'b00101, 3);

      // Abort on the second RUN cycle of 12 - 7.
      subAN = 4'd12; subBN = 4'd7; inValidN = 1'b1;
      @(negedge clk);
      inValidN = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abortValid", 32'(outValidN), 0);
      checkOutput("abortBusy", 32'(busyN), 0);
      checkOutput("abortX", 32'(subXN), 0);
      checkOutput("abortInReady", 32'(inReadyN), 0);
      rst = 1'b0;
      #1;
      checkOutput("abortIdle", 32'(inReadyN), 1);
      applyStimulus(4'd1, 4'd1, 5'b00000, 0);

      applyStimulusWide(8'h10, 8'h01, 9'h00F);
      applyStimulusWide(8'h01, 8'h10, 9'h1F1);

      sent = 0; received = 0; cycles = 0; fireIn = 1'b0;
      while (received < 1000 && cycles < 40000) begin
         @(negedge clk);
         cycles++;
         if (fireIn) inValidN = 1'b0;
         if (!inValidN && sent < 1000 && $urandom_range(0, 3) != 0) begin
            subAN = 4'($urandom_range(0, 15));
            subBN = 4'($urandom_range(0, 15));
            inValidN = 1'b1;
         end
         outReadyN = ($urandom_range(0, 2) != 0);
         #1;
         checkOutput("noOverlap", 32'(inReadyN & outValidN), 0);
         fireIn = inValidN && inReadyN;
         if (fireIn) begin
            expQ.push_back({1'b0, subAN} - {1'b0, subBN});
            sent++;
         end
         if (outValidN && outReadyN) begin
            if (expQ.size() == 0) checkOutput("streamUnexpected", 1, 0);
            else checkOutput("streamX", 32'(subXN), 32'(expQ.pop_front()));
            received++;
         end
      end
      checkOutput("streamCount", received, 1000);
      checkOutput("streamLeft", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle digit-serial subtractor; the inverse operation of the team's combinational adder.
- Accepts an operand pair A, B over a valid/ready handshake.
- Computes X = A - B one DIGIT_WIDTH-bit digit per clock, LSB digit first, with the borrow held in a flop.
- Returns the (DATA_WIDTH+1)-bit two's-complement result over a second valid/ready handshake.
- Sits alongside the adder in the arithmetic datapath, where area matters more than latency.

Parameters:
- DATA_WIDTH, 4, operand width in bits; must be an integer multiple of DIGIT_WIDTH.
- DIGIT_WIDTH, 1, bits processed per cycle; 1 <= DIGIT_WIDTH <= DATA_WIDTH.
- NUM_DIGITS, derived localparam, equal to DATA_WIDTH/DIGIT_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on sub_A/sub_B is valid.
- in_ready  output  1  block can accept an operand pair.
- sub_A  input  DATA_WIDTH  minuend, unsigned.
- sub_B  input  DATA_WIDTH  subtrahend, unsigned.
- out_valid  output  1  sub_X holds a completed result.
- out_ready  input  1  consumer accepts the result.
- sub_X  output  DATA_WIDTH+1  result; [DATA_WIDTH-1:0] is the difference, [DATA_WIDTH] is the final borrow (sign).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: synchronous, active-high, named rst; clock named clk.
  - With rst high at an edge: state <= IDLE; out_valid, busy, sub_X, the borrow flop and the digit counter all go to 0; the captured operands are don't-care.
  - in_ready is 0 while rst is high.
- Arithmetic: sub_X = {1'b0,A} - {1'b0,B} mod 2^(DATA_WIDTH+1).
  - Equivalently, sub_X + B == {1'b0,A} mod 2^(DATA_WIDTH+1).
  - sub_X[DATA_WIDTH] = 1 exactly when A < B.
- IDLE:
  - in_ready = 1, out_valid = 0, busy = 0.
  - An edge with in_valid && in_ready: latch sub_A, sub_B; clear borrow = 0 and digit count = 0; go to RUN.
- RUN:
  - in_ready = 0, busy = 1.
  - Each cycle: {b_next, d} = A_digit[count] - B_digit[count] - borrow, computed DIGIT_WIDTH+1 bits wide. Write d into result digit[count]; borrow <= b_next; count++.
  - On the edge that processes digit NUM_DIGITS-1: set sub_X[DATA_WIDTH] = b_next and go to DONE.
  - Inputs are ignored during RUN; the latched operands are used.
- DONE:
  - out_valid = 1, busy = 1, in_ready = 0.
  - sub_X is held stable until the handshake completes.
  - An edge with out_valid && out_ready: out_valid <= 0, go to IDLE. sub_X keeps its last value until the next result.
- Latency: from the acceptance edge, out_valid rises exactly NUM_DIGITS edges later. With out_ready held high, throughput is one result per NUM_DIGITS+2 cycles.
- No overlap: in_ready is never high in the same cycle as out_valid. A new operand is accepted at the earliest one cycle after output acceptance.
- in_valid high with in_ready low: no effect. The upstream must hold in_valid and its data until accepted.
- out_ready high outside DONE: no effect.
- Reset during RUN or DONE: the operation is aborted and the result discarded; no out_valid pulse is produced.
- Edge values:
  - A = B gives sub_X = 0.
  - A = 0, B = 2^W-1 gives the maximum borrow case, sub_X = 2^W + 1.
  - No overflow exists beyond the sign bit.

Test Plan:
- W=4, D=1; A=5, B=3, out_ready=1 -> out_valid rises 4 edges after acceptance; sub_X = 5'b00010; returns to IDLE the next edge.
- W=4, D=1; A=3, B=5 -> sub_X = 5'b11110 (-2); A=0, B=15 -> sub_X = 5'b10001; A=15, B=15 -> sub_X = 0.
- Backpressure: A=9, B=4 with out_ready held low 3 cycles in DONE -> out_valid and sub_X = 5'b00101 stay stable; in_ready stays 0; in_valid pulses during this time are ignored.
- Reset mid-RUN: assert rst on the 2nd RUN cycle of A=12, B=7 -> next cycle out_valid=0, busy=0, sub_X=0; with rst low, in_ready=1 and a fresh A=1, B=1 yields sub_X=0.
- W=8, D=4 (NUM_DIGITS=2); A=0x10, B=0x01 -> sub_X = 9'h00F after 2 edges; the borrow propagates across the digit boundary.
- Randomised back-to-back stream of 1000 pairs with random in_valid/out_ready -> every sub_X equals the model ({1'b0,A}-{1'b0,B}) mod 2^(W+1), in order, with no drops or duplicates.
